// File: rtl/pipe_pkg.sv
// Shared widths, MEM-stage FSM encoding and pipeline-register layouts for result_pipe.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int REG_AW = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic [DATA_W-1:0] data;
    } mem_wb_t;

endpackage

// File: rtl/result_pipe_hazard.sv
// Stall decisions for the result pipe: memory freeze and load-use interlock.
// Optional stall counters are built when RESULT_PIPE_PERF_EN is defined.
module result_pipe_hazard #(
    parameter int REG_AW = 5
) (
`ifdef RESULT_PIPE_PERF_EN
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       perf_mem_stall_cycles_o,
    output logic [31:0]       perf_load_use_cycles_o,
`endif
    input  logic              mem_op_i,
    input  logic              dmem_stall_i,
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              pipe_stall_o,
    output logic              load_use_stall_o
);

    assign pipe_stall_o = mem_op_i & dmem_stall_i;

    // A frozen pipe already holds the consumer, so the interlock stays quiet then.
    assign load_use_stall_o = ex_valid_i & ex_memread_i & (ex_rd_i != '0)
                            & ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i))
                            & ~pipe_stall_o;

`ifdef RESULT_PIPE_PERF_EN
    logic [31:0] mem_stall_cnt_q;
    logic [31:0] load_use_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_stall_cnt_q <= '0;
            load_use_cnt_q  <= '0;
        end else begin
            if (pipe_stall_o && (mem_stall_cnt_q != '1)) mem_stall_cnt_q <= mem_stall_cnt_q + 32'd1;
            if (load_use_stall_o && (load_use_cnt_q != '1)) load_use_cnt_q <= load_use_cnt_q + 32'd1;
        end
    end

    assign perf_mem_stall_cycles_o = mem_stall_cnt_q;
    assign perf_load_use_cycles_o  = load_use_cnt_q;
`endif

endmodule

// File: rtl/result_pipe.sv
// EX/MEM and MEM/WB result registers feeding operand forwarding, MEM-stage data access,
// and stall generation. Define RESULT_PIPE_PERF_EN to add the stall performance counters.
module result_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [REG_AW-1:0] ex_mem_rd,
    output logic [REG_AW-1:0] mem_wb_rd,
    output logic              ex_mem_regwrite,
    output logic              mem_wb_regwrite,
    output logic [DATA_W-1:0] ex_mem_data,
    output logic [DATA_W-1:0] mem_wb_data,
`ifdef RESULT_PIPE_PERF_EN
    output logic [31:0]       perf_mem_stall_cycles,
    output logic [31:0]       perf_load_use_cycles,
`endif
    output logic              pipe_stall,
    output logic              load_use_stall
);

    import pipe_pkg::*;

    ex_mem_t    ex_mem_q, ex_mem_d;
    mem_wb_t    mem_wb_q, mem_wb_d;
    mem_state_e state_q;
    logic       mem_op;

    assign mem_op = ex_mem_q.memread | ex_mem_q.memwrite;

    result_pipe_hazard #(.REG_AW(REG_AW)) u_hazard (
`ifdef RESULT_PIPE_PERF_EN
        .clk                     (clk),
        .rst_n                   (rst_n),
        .perf_mem_stall_cycles_o (perf_mem_stall_cycles),
        .perf_load_use_cycles_o  (perf_load_use_cycles),
`endif
        .mem_op_i                (mem_op),
        .dmem_stall_i            (dmem_stall),
        .ex_valid_i              (ex_valid),
        .ex_memread_i            (ex_memread),
        .ex_rd_i                 (ex_rd),
        .id_rs_i                 (id_rs),
        .id_rt_i                 (id_rt),
        .pipe_stall_o            (pipe_stall),
        .load_use_stall_o        (load_use_stall)
    );

    always_comb begin
        // NOTE: every field starts from its held value so no path through this block infers a latch.
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (pipe_stall) begin
            mem_wb_d.rd       = '0;
            mem_wb_d.regwrite = 1'b0;
        end else begin
            ex_mem_d.rd         = ex_rd;
            ex_mem_d.regwrite   = ex_valid & ex_regwrite & ~ex_memwrite;
            ex_mem_d.memread    = ex_valid & ex_memread;
            ex_mem_d.memwrite   = ex_valid & ex_memwrite;
            ex_mem_d.alu_result = ex_alu_result;
            ex_mem_d.store_data = ex_store_data;
            mem_wb_d.rd         = ex_mem_q.rd;
            mem_wb_d.regwrite   = ex_mem_q.regwrite;
            mem_wb_d.data       = ex_mem_q.memread ? dmem_rdata : ex_mem_q.alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state is updated with <= only, so every register samples pre-edge values.
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            state_q  <= IDLE;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            case (state_q)
                IDLE:    if (mem_op && dmem_stall) state_q <= ACCESS;
                ACCESS:  if (!dmem_stall) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_read       = ex_mem_q.memread;
    assign dmem_write      = ex_mem_q.memwrite;
    assign dmem_addr       = ex_mem_q.alu_result[ADDR_W+1:2];
    assign dmem_wdata      = ex_mem_q.store_data;
    assign ex_mem_rd       = ex_mem_q.rd;
    // A load's value does not exist yet in EX/MEM, so it is never offered for forwarding.
    assign ex_mem_regwrite = ex_mem_q.regwrite & ~ex_mem_q.memread;
    assign ex_mem_data     = ex_mem_q.alu_result;
    assign mem_wb_rd       = mem_wb_q.rd;
    assign mem_wb_regwrite = mem_wb_q.regwrite;
    assign mem_wb_data     = mem_wb_q.data;

endmodule

// File: tb/tb_result_pipe.sv
// Self-checking bench for result_pipe: directed scenarios, then random traffic against an
// instruction-level model with its own data memory.
module tb_result_pipe;

    typedef enum {K_ALU, K_LOAD, K_STORE} kind_e;

    typedef struct {
        bit          valid;
        kind_e       kind;
        bit          writes;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] sdata;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic [31:0] ex_alu_result, ex_store_data, dmem_rdata;
    logic        dmem_stall;
    logic        dmem_read, dmem_write;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        ex_mem_regwrite, mem_wb_regwrite;
    logic [31:0] ex_mem_data, mem_wb_data;
    logic        pipe_stall, load_use_stall;
`ifdef RESULT_PIPE_PERF_EN
    logic [31:0] perf_mem_stall_cycles, perf_load_use_cycles;
`endif

    always #5 clk = ~clk;

    result_pipe dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_regwrite     (ex_regwrite),
        .ex_memread      (ex_memread),
        .ex_memwrite     (ex_memwrite),
        .ex_alu_result   (ex_alu_result),
        .ex_store_data   (ex_store_data),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .dmem_rdata      (dmem_rdata),
        .dmem_stall      (dmem_stall),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_rd       (mem_wb_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_regwrite (mem_wb_regwrite),
        .ex_mem_data     (ex_mem_data),
        .mem_wb_data     (mem_wb_data),
`ifdef RESULT_PIPE_PERF_EN
        .perf_mem_stall_cycles (perf_mem_stall_cycles),
        .perf_load_use_cycles  (perf_load_use_cycles),
`endif
        .pipe_stall      (pipe_stall),
        .load_use_stall  (load_use_stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: the instruction sitting in the MEM stage, the last retired result, and memory contents.
    logic [31:0] mem [bit [29:0]];
    instr_t      in_mem;
    instr_t      cur;
    bit          cur_rst;
    logic [4:0]  wb_rd;
    bit          wb_we;
    logic [31:0] wb_data;
    bit          exp_stall, exp_lu;
    int unsigned cnt_mem_stall, cnt_load_use;

    function automatic logic [31:0] mem_get(input bit [29:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic bit is_mem_op(input instr_t i);
        return i.valid && (i.kind != K_ALU);
    endfunction

    function automatic void model_reset();
        in_mem = '{valid: 1'b0, kind: K_ALU, writes: 1'b0, rd: 5'd0, result: 32'd0, sdata: 32'd0};
        wb_rd = '0; wb_we = 1'b0; wb_data = '0;
        cnt_mem_stall = 0; cnt_load_use = 0;
    endfunction

    // Apply one cycle's inputs, then compare every output with what the model predicts.
    task automatic drive(input bit rst, input bit v, input kind_e k, input bit rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rs,
                         input logic [4:0] rt, input bit st);
        bit ld_in_mem;
        rst_n = ~rst;
        ex_valid = v; ex_memread = (k == K_LOAD); ex_memwrite = (k == K_STORE); ex_regwrite = rw;
        ex_rd = rd; ex_alu_result = alu; ex_store_data = sd; id_rs = rs; id_rt = rt; dmem_stall = st;
        cur = '{valid: v, kind: k, writes: v && rw && (k != K_STORE), rd: rd, result: alu, sdata: sd};
        cur_rst = rst;
        ld_in_mem = in_mem.valid && (in_mem.kind == K_LOAD);
        dmem_rdata = ld_in_mem ? mem_get(in_mem.result[31:2]) : $urandom;
        exp_stall = is_mem_op(in_mem) && st;
        exp_lu = v && (k == K_LOAD) && (rd != 0) && (rd == rs || rd == rt) && !exp_stall;
        #1;
        check("dmem_read",       32'(dmem_read),       32'(ld_in_mem));
        check("dmem_write",      32'(dmem_write),      32'(in_mem.valid && in_mem.kind == K_STORE));
        check("dmem_addr",       32'(dmem_addr),       {2'b00, in_mem.result[31:2]});
        check("dmem_wdata",      dmem_wdata,           in_mem.sdata);
        check("ex_mem_rd",       32'(ex_mem_rd),       32'(in_mem.rd));
        check("ex_mem_regwrite", 32'(ex_mem_regwrite), 32'(in_mem.writes && in_mem.kind != K_LOAD));
        check("ex_mem_data",     ex_mem_data,          in_mem.result);
        check("mem_wb_rd",       32'(mem_wb_rd),       32'(wb_rd));
        check("mem_wb_regwrite", 32'(mem_wb_regwrite), 32'(wb_we));
        check("mem_wb_data",     mem_wb_data,          wb_data);
        check("pipe_stall",      32'(pipe_stall),      32'(exp_stall));
        check("load_use_stall",  32'(load_use_stall),  32'(exp_lu));
`ifdef RESULT_PIPE_PERF_EN
        check("perf_mem_stall",  perf_mem_stall_cycles, cnt_mem_stall);
        check("perf_load_use",   perf_load_use_cycles,  cnt_load_use);
`endif
    endtask

    // Advance one clock and retire/advance instructions in the model.
    task automatic tick();
        @(posedge clk);
        if (cur_rst) begin
            model_reset();
        end else begin
            if (exp_stall && cnt_mem_stall != 32'hFFFF_FFFF) cnt_mem_stall++;
            if (exp_lu && cnt_load_use != 32'hFFFF_FFFF) cnt_load_use++;
            if (exp_stall) begin
                wb_rd = '0;
                wb_we = 1'b0;
            end else begin
                wb_rd = in_mem.rd;
                wb_we = in_mem.writes;
                wb_data = (in_mem.valid && in_mem.kind == K_LOAD) ? mem_get(in_mem.result[31:2])
                                                                  : in_mem.result;
                if (in_mem.valid && in_mem.kind == K_STORE) mem[in_mem.result[31:2]] = in_mem.sdata;
                in_mem = cur;
            end
        end
        @(negedge clk);
    endtask

    task automatic bubble(input bit st);
        drive(1'b0, 1'b0, K_ALU, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, st);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
        ex_rd = 0; id_rs = 0; id_rt = 0; ex_alu_result = 0; ex_store_data = 0;
        dmem_rdata = 0; dmem_stall = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        drive(1'b1, 1'b0, K_ALU, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0); tick();

        // Load stalled for three cycles
        mem[30'h10] = 32'h0000_CAFE;
        drive(1'b0, 1'b1, K_LOAD, 1'b1, 5'd9, 32'h40, 32'd0, 5'd1, 5'd2, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            bubble(1'b1);
            check("s2_read", 32'(dmem_read), 32'd1);
            check("s2_addr", 32'(dmem_addr), 32'h10);
            check("s2_pstall", 32'(pipe_stall), 32'd1);
            check("s2_fwd_we", 32'(ex_mem_regwrite), 32'd0);
            tick();
            check("s2_wb_bubble", 32'(mem_wb_regwrite), 32'd0);
        end
        bubble(1'b0);
        check("s2_read_last", 32'(dmem_read), 32'd1);
        check("s2_pstall_last", 32'(pipe_stall), 32'd0);
        tick();
        bubble(1'b0);
        check("s2_wb_rd", 32'(mem_wb_rd), 32'd9);
        check("s2_wb_data", mem_wb_data, 32'h0000_CAFE);
        tick();

        // Load-use detection
        drive(1'b0, 1'b1, K_LOAD, 1'b1, 5'd5, 32'h44, 32'd0, 5'd1, 5'd5, 1'b0);
        check("s3_hit", 32'(load_use_stall), 32'd1);
        tick();
        drive(1'b0, 1'b1, K_LOAD, 1'b1, 5'd5, 32'h48, 32'd0, 5'd6, 5'd6, 1'b0);
        check("s3_miss", 32'(load_use_stall), 32'd0);
        tick();
        drive(1'b0, 1'b1, K_LOAD, 1'b1, 5'd0, 32'h4C, 32'd0, 5'd0, 5'd0, 1'b0);
        check("s3_rd0", 32'(load_use_stall), 32'd0);
        tick();
        bubble(1'b0); tick();
        bubble(1'b0); tick();
`ifdef RESULT_PIPE_PERF_EN
        check("s6_perf_mem", perf_mem_stall_cycles, 32'd3);
        check("s6_perf_lu",  perf_load_use_cycles,  32'd1);
`endif

        // ALU forwarding path
        drive(1'b0, 1'b1, K_ALU, 1'b1, 5'd8, 32'h1234, 32'd0, 5'd0, 5'd0, 1'b0); tick();
        bubble(1'b0);
        check("s1_ex_rd", 32'(ex_mem_rd), 32'd8);
        check("s1_ex_we", 32'(ex_mem_regwrite), 32'd1);
        check("s1_ex_data", ex_mem_data, 32'h1234);
        tick();
        bubble(1'b0);
        check("s1_wb_data", mem_wb_data, 32'h1234);
        check("s1_wb_we", 32'(mem_wb_regwrite), 32'd1);
        tick();

        // Store
        drive(1'b0, 1'b1, K_STORE, 1'b0, 5'd3, 32'h80, 32'hBEEF, 5'd0, 5'd0, 1'b0); tick();
        bubble(1'b0);
        check("s4_write", 32'(dmem_write), 32'd1);
        check("s4_addr", 32'(dmem_addr), 32'h20);
        check("s4_wdata", dmem_wdata, 32'hBEEF);
        tick();
        bubble(1'b0);
        check("s4_wb_we", 32'(mem_wb_regwrite), 32'd0);
        tick();

        // Reset during a stalled load, then a clean ALU op
        drive(1'b0, 1'b1, K_LOAD, 1'b1, 5'd9, 32'h40, 32'd0, 5'd0, 5'd0, 1'b0); tick();
        bubble(1'b1); tick();
        drive(1'b1, 1'b0, K_ALU, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1); tick();
        bubble(1'b0);
        check("s5_read", 32'(dmem_read), 32'd0);
        check("s5_wb_rd", 32'(mem_wb_rd), 32'd0);
        tick();
        drive(1'b0, 1'b1, K_ALU, 1'b1, 5'd8, 32'h1234, 32'd0, 5'd0, 5'd0, 1'b0); tick();
        bubble(1'b0);
        check("s5_ex_data", ex_mem_data, 32'h1234);
        tick();
        bubble(1'b0);
        check("s5_wb_data", mem_wb_data, 32'h1234);
        tick();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            kind_e       k;
            logic [31:0] alu;
            k   = kind_e'($urandom_range(0, 2));
            alu = (k == K_ALU) ? $urandom : 32'($urandom_range(0, 255));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, k,
                  (k == K_LOAD) ? 1'b1 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  alu, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
